// File: rtl/mdc_pkg.sv
// Shared definitions for the MDC input front end: frame geometry, code widths,
// FSM states and the saturating error-counter helper.
package mdc_pkg;

    localparam int N_WORDS     = 16;
    localparam int DW          = 11;
    localparam int CODE_W      = 15;
    localparam int MODE_CODE_W = 9;
    localparam int MODE_W      = 5;
    localparam int CNT_W       = 4;
    localparam int ERR_W       = 5;

    // 16 data words plus the mode word is the most corrections one frame can hold.
    localparam logic [ERR_W-1:0] ERR_MAX = 5'd17;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        OUT
    } state_t;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] value,
                                                 input logic inc);
        if (inc && (value != ERR_MAX)) begin
            return value + 1'b1;
        end
        return value;
    endfunction

endpackage

// File: rtl/hamming_dec.sv
// Combinational single-error-correcting Hamming decoder. code[N-1] is position 1,
// parity bits sit at power-of-two positions, and the lowest data position is the data MSB.
module hamming_dec #(
    parameter int N = 15,
    parameter int K = 11
) (
    input  logic [N-1:0] code,
    output logic [K-1:0] data,
    output logic         corrected,
    output logic         uncorrectable
);

    localparam int SW = $clog2(N + 1);

    logic [SW-1:0] syndrome;
    logic [N-1:0]  fixed;

    // Number of data positions that precede position p.
    function automatic int data_rank(input int p);
        int n;
        n = 0;
        for (int q = 1; q < p; q++) begin
            if ((q & (q - 1)) != 0) begin
                n++;
            end
        end
        return n;
    endfunction

    always_comb begin
        syndrome = '0;
        for (int p = 1; p <= N; p++) begin
            if (code[N-p]) begin
                syndrome = syndrome ^ SW'(p);
            end
        end
    end

    // A syndrome that points beyond the code word cannot be a single-bit error.
    always_comb begin
        fixed         = code;
        corrected     = 1'b0;
        uncorrectable = 1'b0;
        if (syndrome != '0) begin
            if (int'(syndrome) <= N) begin
                corrected = 1'b1;
                for (int p = 1; p <= N; p++) begin
                    if (int'(syndrome) == p) begin
                        fixed[N-p] = ~code[N-p];
                    end
                end
            end else begin
                uncorrectable = 1'b1;
            end
        end
    end

    always_comb begin
        data = '0;
        for (int p = 1; p <= N; p++) begin
            if ((p & (p - 1)) != 0) begin
                data[K-1-data_rank(p)] = fixed[N-p];
            end
        end
    end

endmodule

// File: rtl/mdc_input_frontend.sv
// Collects a frame of Hamming(15,11) words plus one Hamming(9,5) mode word, corrects
// them on the way in and presents the decoded frame for exactly one cycle.
module mdc_input_frontend #(
    parameter int N_WORDS = mdc_pkg::N_WORDS,
    parameter int DW      = mdc_pkg::DW
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    input  logic [mdc_pkg::CODE_W-1:0]      in_data,
    input  logic [mdc_pkg::MODE_CODE_W-1:0] in_mode,
    output logic                            out_valid,
    output logic [N_WORDS*DW-1:0]           out_matrix,
    output logic [mdc_pkg::MODE_W-1:0]      out_mode,
    output logic [mdc_pkg::ERR_W-1:0]       err_cnt,
    output logic                            mode_bad
);

    import mdc_pkg::*;

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(N_WORDS - 1);

    state_t                state;
    state_t                next_state;
    logic [CNT_W-1:0]      word_cnt;
    logic [N_WORDS*DW-1:0] buffer;
    logic [MODE_W-1:0]     mode_reg;
    logic [ERR_W-1:0]      err_reg;
    logic                  mode_bad_reg;

    logic [DW-1:0]         word_data;
    logic                  word_corr;
    logic                  word_unc;
    logic                  word_fix;
    logic [MODE_W-1:0]     mode_data;
    logic                  mode_corr;
    logic                  mode_unc;

    logic                  start_frame;
    logic                  store_word;
    logic                  abort_frame;

    hamming_dec #(.N(CODE_W), .K(DW)) u_data_dec (
        .code          (in_data),
        .data          (word_data),
        .corrected     (word_corr),
        .uncorrectable (word_unc)
    );

    hamming_dec #(.N(MODE_CODE_W), .K(MODE_W)) u_mode_dec (
        .code          (in_mode),
        .data          (mode_data),
        .corrected     (mode_corr),
        .uncorrectable (mode_unc)
    );

    assign word_fix = word_corr & ~word_unc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A frame may start from IDLE or straight out of the presentation cycle.
    always_comb begin
        next_state  = state;
        start_frame = 1'b0;
        store_word  = 1'b0;
        abort_frame = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    start_frame = 1'b1;
                    next_state  = RECV;
                end
            end
            RECV: begin
                if (in_valid) begin
                    store_word = 1'b1;
                    if (word_cnt == LAST_WORD) begin
                        next_state = OUT;
                    end
                end else begin
                    abort_frame = 1'b1;
                    next_state  = IDLE;
                end
            end
            OUT: begin
                if (in_valid) begin
                    start_frame = 1'b1;
                    next_state  = RECV;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt     <= '0;
            buffer       <= '0;
            mode_reg     <= '0;
            err_reg      <= '0;
            mode_bad_reg <= 1'b0;
        end else if (start_frame) begin
            buffer[DW-1:0] <= word_data;
            word_cnt       <= CNT_W'(1);
            mode_reg       <= mode_data;
            mode_bad_reg   <= mode_unc;
            err_reg        <= ERR_W'(word_fix) + ERR_W'(mode_corr);
        end else if (store_word) begin
            buffer[int'(word_cnt)*DW +: DW] <= word_data;
            word_cnt                        <= word_cnt + 1'b1;
            err_reg                         <= sat_inc(err_reg, word_fix);
        end else if (abort_frame) begin
            buffer   <= '0;
            word_cnt <= '0;
        end
    end

    // Outputs are gated by the OUT state so reset and idle cycles read as zero.
    assign out_valid  = (state == OUT);
    assign out_matrix = out_valid ? buffer       : '0;
    assign out_mode   = out_valid ? mode_reg     : '0;
    assign err_cnt    = out_valid ? err_reg      : '0;
    assign mode_bad   = out_valid ? mode_bad_reg : 1'b0;

endmodule
